// File: rtl/modulation_segment_sampler.sv
// rtl/modulation_segment_sampler.sv - segment selection, switch scheduling and aligned modulation BRAM read
module modulation_segment_sampler #(
    parameter int          BRAM_LATENCY = 2,
    parameter logic [15:0] REP_INF      = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [14:0] IDX_0,
    input  logic [14:0] IDX_1,
    input  logic [14:0] CYCLE_0,
    input  logic [14:0] CYCLE_1,
    input  logic        REQ_VALID,
    input  logic        REQ_SEGMENT,
    input  logic [1:0]  REQ_MODE,
    input  logic [15:0] REQ_REP,
    output logic [15:0] BRAM_ADDR,
    input  logic [7:0]  BRAM_DOUT,
    output logic [7:0]  MOD_VALUE,
    output logic        MOD_VALID,
    output logic        SEGMENT,
    output logic [14:0] IDX,
    output logic        PENDING
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_WRAP,
        ST_WAIT_LOOP
    } state_t;

    state_t      state, state_n;
    logic        active_seg, seg_n;
    logic        pend_seg, pend_n;
    logic [15:0] loop_cnt, cnt_n;
    logic [15:0] rep_lat, rep_n;
    logic [14:0] idx_prev;

    logic [14:0] idx_seg0, idx_seg1, idx_act, idx_eff;
    logic        single_sample, wrap, fire;

    logic        addr_vld;
    logic        pipe_vld [BRAM_LATENCY];
    logic        pipe_seg [BRAM_LATENCY];
    logic [14:0] pipe_idx [BRAM_LATENCY];

    // A timer index may briefly exceed a freshly shortened cycle; clamp it.
    function automatic logic [14:0] clamp_idx(input logic [14:0] idx, input logic [14:0] last);
        return (idx > last) ? last : idx;
    endfunction

    assign idx_seg0      = clamp_idx(IDX_0, CYCLE_0);
    assign idx_seg1      = clamp_idx(IDX_1, CYCLE_1);
    assign idx_act       = active_seg ? idx_seg1 : idx_seg0;
    assign single_sample = active_seg ? (CYCLE_1 == 15'd0) : (CYCLE_0 == 15'd0);
    assign wrap          = idx_act < idx_prev;
    // The sample of a switch cycle already comes from the new segment.
    assign idx_eff       = seg_n ? idx_seg1 : idx_seg0;
    assign PENDING       = (state != ST_IDLE);

    // Switch scheduling: new requests take priority over wraps seen in the same cycle.
    always_comb begin
        state_n = state;
        seg_n   = active_seg;
        pend_n  = pend_seg;
        cnt_n   = loop_cnt;
        rep_n   = rep_lat;
        fire    = 1'b0;
        if (REQ_VALID && (REQ_MODE != 2'd3)) begin
            cnt_n  = 16'd0;
            pend_n = REQ_SEGMENT;
            case (REQ_MODE)
                2'd0: begin
                    seg_n   = REQ_SEGMENT;
                    state_n = ST_IDLE;
                end
                2'd1: state_n = ST_WAIT_WRAP;
                default: begin
                    rep_n   = REQ_REP;
                    state_n = ST_WAIT_LOOP;
                end
            endcase
        end else begin
            case (state)
                ST_WAIT_WRAP: fire = wrap || single_sample;
                ST_WAIT_LOOP: begin
                    if (rep_lat != REP_INF) begin
                        fire = single_sample || (wrap && (loop_cnt == rep_lat));
                    end
                    if (wrap && !fire && (loop_cnt != 16'hFFFF)) begin
                        cnt_n = loop_cnt + 16'd1;
                    end
                end
                default: fire = 1'b0;
            endcase
            if (fire) begin
                seg_n   = pend_seg;
                state_n = ST_IDLE;
            end
        end
    end

    // Control state and wrap history; history follows the segment used this cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            active_seg <= 1'b0;
            pend_seg   <= 1'b0;
            loop_cnt   <= 16'd0;
            rep_lat    <= 16'd0;
            idx_prev   <= 15'd0;
        end else begin
            state      <= state_n;
            active_seg <= seg_n;
            pend_seg   <= pend_n;
            loop_cnt   <= cnt_n;
            rep_lat    <= rep_n;
            idx_prev   <= idx_eff;
        end
    end

    // Address issue, tag delay matching the BRAM latency, and output capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BRAM_ADDR <= 16'd0;
            addr_vld  <= 1'b0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_seg[i] <= 1'b0;
                pipe_idx[i] <= 15'd0;
            end
            MOD_VALUE <= 8'd0;
            MOD_VALID <= 1'b0;
            SEGMENT   <= 1'b0;
            IDX       <= 15'd0;
        end else begin
            BRAM_ADDR   <= {seg_n, idx_eff};
            addr_vld    <= 1'b1;
            pipe_vld[0] <= addr_vld;
            pipe_seg[0] <= BRAM_ADDR[15];
            pipe_idx[0] <= BRAM_ADDR[14:0];
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_seg[i] <= pipe_seg[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            MOD_VALUE <= BRAM_DOUT;
            MOD_VALID <= pipe_vld[BRAM_LATENCY-1];
            SEGMENT   <= pipe_seg[BRAM_LATENCY-1];
            IDX       <= pipe_idx[BRAM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_modulation_segment_sampler.sv
// tb/tb_modulation_segment_sampler.sv - scoreboard bench for modulation_segment_sampler
module tb_modulation_segment_sampler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [14:0] IDX_0 = '0, IDX_1 = '0, CYCLE_0 = '0, CYCLE_1 = '0;
    logic        REQ_VALID = 1'b0, REQ_SEGMENT = 1'b0;
    logic [1:0]  REQ_MODE = '0;
    logic [15:0] REQ_REP = '0;
    logic [15:0] BRAM_ADDR;
    logic [7:0]  BRAM_DOUT = '0;
    logic [7:0]  MOD_VALUE;
    logic        MOD_VALID, SEGMENT, PENDING;
    logic [14:0] IDX;

    modulation_segment_sampler dut (
        .CLK(CLK), .RST(RST), .IDX_0(IDX_0), .IDX_1(IDX_1),
        .CYCLE_0(CYCLE_0), .CYCLE_1(CYCLE_1), .REQ_VALID(REQ_VALID),
        .REQ_SEGMENT(REQ_SEGMENT), .REQ_MODE(REQ_MODE), .REQ_REP(REQ_REP),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_DOUT(BRAM_DOUT), .MOD_VALUE(MOD_VALUE),
        .MOD_VALID(MOD_VALID), .SEGMENT(SEGMENT), .IDX(IDX), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] sb [$];
    logic        draining = 1'b0;
    logic [14:0] p0, p1, c0, c1;
    int          ovr0 = -1;
    logic [15:0] exp_addr;
    int          wraps;

    function automatic logic [7:0] bram_data(input logic [15:0] a);
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'h5A;
    endfunction

    // Two-register BRAM model: data valid two cycles after the address.
    logic [7:0] rd1 = '0;
    always @(posedge CLK) begin
        rd1       <= bram_data(BRAM_ADDR);
        BRAM_DOUT <= rd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sample cycle: advance both timers, drive, record the expected output.
    task automatic tick(input logic es, input logic rv, input logic rs,
                        input logic [1:0] rm, input logic [15:0] rr);
        logic [14:0] ei;
        if (ovr0 >= 0) p0 = ovr0[14:0];
        else           p0 = (p0 >= c0) ? 15'd0 : p0 + 15'd1;
        p1 = (p1 >= c1) ? 15'd0 : p1 + 15'd1;
        IDX_0 = p0; IDX_1 = p1; CYCLE_0 = c0; CYCLE_1 = c1;
        REQ_VALID = rv; REQ_SEGMENT = rs; REQ_MODE = rm; REQ_REP = rr;
        ei = es ? ((p1 > c1) ? c1 : p1) : ((p0 > c0) ? c0 : p0);
        exp_addr = {es, ei};
        sb.push_back({es, ei, bram_data({es, ei})});
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic tick0(input logic es);
        tick(es, 1'b0, 1'b0, 2'd0, 16'd0);
    endtask

    // Output side of the scoreboard.
    always @(negedge CLK) begin
        logic [23:0] e;
        if (MOD_VALID) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("mod_out", {8'd0, SEGMENT, IDX, MOD_VALUE}, {8'd0, e});
            end else if (!draining) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end
        end
    end

    initial begin
        c0 = 15'd9; c1 = 15'd63; p0 = 15'd9; p1 = 15'd63;
        CYCLE_0 = c0; CYCLE_1 = c1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_addr", 32'(BRAM_ADDR), 32'd0);
        check_eq("rst_valid", 32'(MOD_VALID), 32'd0);
        check_eq("rst_pending", 32'(PENDING), 32'd0);
        check_eq("rst_segment", 32'(SEGMENT), 32'd0);
        check_eq("rst_idx", 32'(IDX), 32'd0);
        check_eq("rst_value", 32'(MOD_VALUE), 32'd0);
        RST = 1'b0;

        // Ramp through segment 0
        for (int k = 0; k < 10; k++) begin
            tick0(1'b0);
            check_eq("ramp_addr", 32'(BRAM_ADDR), 32'(k));
            check_eq("valid_rise", 32'(MOD_VALID), (k >= 3) ? 32'd1 : 32'd0);
        end

        // Immediate switch to segment 1 at IDX_1 = 37
        while (p1 != 15'd36) tick0(1'b0);
        tick(1'b1, 1'b1, 1'b1, 2'd0, 16'd0);
        check_eq("imm_addr", 32'(BRAM_ADDR), 32'h8025);
        check_eq("imm_pending", 32'(PENDING), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick0(1'b1);
            check_eq("imm_pending_hold", 32'(PENDING), 32'd0);
        end

        // Switch at wrap, requested at IDX_0 = 3
        tick(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        while (p0 != 15'd2) tick0(1'b0);
        tick(1'b0, 1'b1, 1'b1, 2'd1, 16'd0);
        check_eq("wrap_pending_set", 32'(PENDING), 32'd1);
        while (p0 != 15'd9) begin
            tick0(1'b0);
            check_eq("wrap_no_early", 32'(BRAM_ADDR), 32'(exp_addr));
            check_eq("wrap_pending", 32'(PENDING), 32'd1);
        end
        tick0(1'b1);
        check_eq("wrap_switch_addr", 32'(BRAM_ADDR), 32'(exp_addr));
        check_eq("wrap_pending_clr", 32'(PENDING), 32'd0);

        // Switch after REQ_REP+1 = 3 wraps
        tick(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        while (p0 != 15'd4) tick0(1'b0);
        tick(1'b0, 1'b1, 1'b1, 2'd2, 16'd2);
        check_eq("loop_pending_set", 32'(PENDING), 32'd1);
        wraps = 0;
        for (int k = 0; k < 60; k++) begin
            logic es;
            if (p0 >= c0) wraps++;
            es = (wraps == 3) && (p0 >= c0);
            tick0(es);
            check_eq("loop_addr", 32'(BRAM_ADDR), 32'(exp_addr));
            check_eq("loop_pending", 32'(PENDING), es ? 32'd0 : 32'd1);
            if (es) break;
        end
        check_eq("loop_wraps", 32'(wraps), 32'd3);

        // Repeat-forever never switches
        tick(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        tick(1'b0, 1'b1, 1'b1, 2'd2, 16'hFFFF);
        for (int k = 0; k < 100; k++) begin
            tick0(1'b0);
            check_eq("inf_addr", 32'(BRAM_ADDR), 32'(exp_addr));
        end
        check_eq("inf_pending", 32'(PENDING), 32'd1);

        // Replacement request, then immediate no-op cancels the wait
        tick(1'b0, 1'b1, 1'b1, 2'd1, 16'd0);
        check_eq("repl_pending", 32'(PENDING), 32'd1);
        tick(1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        check_eq("noop_pending", 32'(PENDING), 32'd0);
        for (int k = 0; k < 25; k++) tick0(1'b0);
        check_eq("noop_no_switch", 32'(BRAM_ADDR), 32'(exp_addr));
        tick(1'b0, 1'b1, 1'b1, 2'd3, 16'd0);
        check_eq("mode3_pending", 32'(PENDING), 32'd0);
        tick0(1'b0);
        check_eq("mode3_addr", 32'(BRAM_ADDR), 32'(exp_addr));

        // Reset in the middle of a loop wait
        tick(1'b1, 1'b1, 1'b1, 2'd0, 16'd0);
        tick(1'b1, 1'b1, 1'b0, 2'd2, 16'd5);
        check_eq("pre_rst_pending", 32'(PENDING), 32'd1);
        repeat (3) tick0(1'b1);
        RST = 1'b1;
        @(posedge CLK); #1;
        sb.delete();
        check_eq("mid_rst_segment", 32'(SEGMENT), 32'd0);
        check_eq("mid_rst_pending", 32'(PENDING), 32'd0);
        check_eq("mid_rst_valid", 32'(MOD_VALID), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        tick0(1'b0);
        check_eq("post_rst_addr", 32'(BRAM_ADDR), 32'(exp_addr));
        for (int k = 0; k < 6; k++) tick0(1'b0);

        // Out-of-range index clamps to CYCLE_0
        ovr0 = 12;
        tick0(1'b0);
        ovr0 = -1;
        check_eq("clamp_addr", 32'(BRAM_ADDR), 32'h0009);
        for (int k = 0; k < 3; k++) tick0(1'b0);

        // Single-sample segment: wrap-based request fires one cycle later
        c0 = 15'd0;
        tick0(1'b0);
        tick(1'b0, 1'b1, 1'b1, 2'd1, 16'd0);
        check_eq("single_pending", 32'(PENDING), 32'd1);
        tick0(1'b1);
        check_eq("single_addr", 32'(BRAM_ADDR), 32'(exp_addr));
        check_eq("single_pending_clr", 32'(PENDING), 32'd0);

        draining = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/modulation_segment_sampler.md
Name: modulation_segment_sampler

Overview:
- Sits directly downstream of the modulation timer. Consumes the per-segment sample indices IDX_0/IDX_1 and selects the active segment.
- Handles segment-switch requests: immediate, at end of cycle, or after N repetitions.
- Reads the modulation sample BRAM and delivers an aligned 8-bit modulation value, with segment and index, to the intensity multiplier stage.

Parameters:
- BRAM_LATENCY, 2, fixed read latency of modulation BRAM in cycles (DOUT valid N cycles after ADDR).
- REP_INF, 16'hFFFF, REQ_REP value meaning "repeat forever, never switch".

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- IDX_0  in  15  sample index of segment 0 from timer
- IDX_1  in  15  sample index of segment 1 from timer
- CYCLE_0  in  15  last valid index of segment 0 (cycle length − 1)
- CYCLE_1  in  15  last valid index of segment 1
- REQ_VALID  in  1  one-cycle segment-switch request strobe
- REQ_SEGMENT  in  1  requested segment
- REQ_MODE  in  2  0=immediate, 1=at wrap, 2=after REQ_REP+1 wraps, 3=reserved (ignored)
- REQ_REP  in  16  repetition count for mode 2
- BRAM_ADDR  out  16  {segment, index} read address
- BRAM_DOUT  in  8  BRAM read data
- MOD_VALUE  out  8  modulation sample
- MOD_VALID  out  1  MOD_VALUE/SEGMENT/IDX valid
- SEGMENT  out  1  segment MOD_VALUE came from
- IDX  out  15  index MOD_VALUE came from
- PENDING  out  1  switch request waiting

Behaviour:
- Reset: active segment 0, FSM IDLE, loop counter 0, wrap history cleared. BRAM_ADDR, MOD_VALUE, SEGMENT, IDX, PENDING, MOD_VALID all 0. MOD_VALID drops in the cycle after RST is sampled high.
- Pipeline:
  - IDX sampled at cycle t.
  - BRAM_ADDR registered at t+1.
  - BRAM_DOUT at t+1+BRAM_LATENCY.
  - MOD_VALUE registered at t+2+BRAM_LATENCY (t+4 by default).
  - SEGMENT/IDX delayed identically so all outputs refer to the same sample.
  - MOD_VALID rises 4 cycles after RST deasserts and stays high.
- Index selection: idx = active segment's IDX_x. If idx > that segment's CYCLE_x (transient after cycle update), clamp to CYCLE_x.
- Wrap event: active segment idx_now < idx_prev (previous registered index of the same segment). Wrap history is reloaded on a segment switch, so no false wrap is produced by the switch itself.
- FSM states:
  - IDLE: no pending request. On REQ_VALID:
    - mode 0: switch at next cycle.
    - mode 1: → WAIT_WRAP.
    - mode 2: → WAIT_LOOP, loop counter cleared.
    - mode 3: ignored.
  - WAIT_WRAP: on wrap, active segment ← pending, → IDLE.
  - WAIT_LOOP: counter increments per wrap. When counter == REQ_REP (latched), the next wrap switches and → IDLE. If latched REP == REP_INF, never switches.
- PENDING = 1 in WAIT_WRAP/WAIT_LOOP.
- Switch timing: the sample taken in the switch cycle already uses the new segment's current index. There is no forced reset to 0; both timers run on system time.
- Simultaneous events:
  - REQ_VALID while pending: new request replaces the old one; loop counter cleared.
  - REQ_VALID in the same cycle as a wrap: request latched; that wrap does not count.
  - Request for the already-active segment: mode 0 → no-op, returns to IDLE. Modes 1/2 still wait, then the "switch" is a no-op.
- Active CYCLE_x == 0 (single-sample segment, wraps undetectable): a mode 1/2 request takes effect on the cycle after it is latched.
- Reset mid-wait: pending discarded, segment 0.
- Counter widths: loop counter 16 bit, saturating at 16'hFFFF.

Test Plan:
- Reset, CYCLE_0=9, IDX_0 ramps 0..9 → BRAM_ADDR=0x0000..0x0009 one cycle after each index. MOD_VALUE equals BRAM contents 4 cycles after sampling. MOD_VALID rises 4 cycles after RST falls.
- Mode 0 request to segment 1 while IDX_1=37 → BRAM_ADDR=0x8025 next cycle. PENDING never asserts. SEGMENT=1 four cycles later.
- Mode 1 request with IDX_0 at 3, CYCLE_0=9 → PENDING=1 until IDX_0 goes 9→0. Switch occurs in that cycle; no earlier switch.
- Mode 2, REQ_REP=2 → exactly 3 wraps of segment 0 observed before switching. With REQ_REP=16'hFFFF, no switch over 10 wraps and PENDING stays 1.
- Mode 1 pending then new mode 0 request to segment 0 → immediate no-op, PENDING=0. Assert RST during WAIT_LOOP → segment 0, PENDING=0, MOD_VALID=0.
- IDX_0=12 with CYCLE_0=9 → BRAM_ADDR=0x0009 (clamped).
